apb_timer: RTL and testbench
============================

# apb_timer

APB-slave general-purpose timer on the peripheral bus, driven by one `psel` line of the AHB-to-APB bridge, which masters `penable`/`pwrite`/`paddr`/`pwdata` and samples `prdata`. It has a 16-bit prescaler, a 32-bit auto-reload down-counter, one-shot mode, a sticky underflow flag with maskable interrupt, and a toggling timer output. It has zero wait states, because the bridge has no `pready` input.

## Interface
- Parameters: none. Widths are fixed: prescaler 16 bits, counter 32 bits.
- `hclk` in 1: single clock, shared with the bridge.
- `hreset_n` in 1: asynchronous, active-low reset.
- `psel_i` in 1: slave select, one bit of the bridge `psel_slave_o`.
- `penable_i` in 1: APB access phase.
- `pwrite_i` in 1: 1 = write, 0 = read.
- `paddr_i` in 32: byte address; only [4:2] decoded, [1:0] ignored.
- `pwdata_i` in 32: write data.
- `prdata_o` out 32: read data.
- `irq_o` out 1: level interrupt, `IF & IRQ_EN`.
- `tout_o` out 1: registered toggle output.

## Operation
- Register map (word offsets):
  - 0x00 CTRL: [0] EN, [1] ONESHOT, [2] IRQ_EN, [3] TOUT_EN; upper bits read 0.
  - 0x04 PSC [15:0].
  - 0x08 LOAD [31:0].
  - 0x0C COUNT [31:0]: read returns the live value; write loads the counter directly.
  - 0x10 STATUS: [0] IF, sticky; write 1 clears, write 0 has no effect.
  - 0x14–0x1C: read 0, writes ignored.
- Write strobe: `psel_i & penable_i & pwrite_i`, committed at that clock edge.
- Read data: combinational decode of `paddr_i` when `psel_i & ~pwrite_i`; otherwise `prdata_o` = 0.
- Prescaler: an internal 16-bit counter `pcnt`.
  - Runs only while EN = 1.
  - When `pcnt == PSC`, `pcnt` ← 0 and a tick fires; otherwise `pcnt` increments.
  - `pcnt` is forced to 0 while EN = 0 and on the write that sets EN from 0 to 1.
- On each tick:
  - If COUNT ≠ 0: COUNT ← COUNT − 1.
  - If COUNT == 0 (underflow):
    - IF ← 1.
    - If TOUT_EN = 1, `tout_o` toggles.
    - If ONESHOT = 0: COUNT ← LOAD.
    - If ONESHOT = 1: EN ← 0 and COUNT stays 0.
- Period: (PSC+1)·(LOAD+1) cycles in continuous mode. LOAD = 0 gives an underflow on every tick.
- Writing LOAD does not disturb COUNT; the new value is used at the next reload.
- Clearing EN freezes COUNT at its current value.

## Timing
- Reset values:
  - All registers 0 and `pcnt` 0.
  - `irq_o` 0, `tout_o` 0, `prdata_o` 0.
- Latency:
  - A register write is visible on reads and in behaviour from the cycle after the write edge.
  - With PSC = 0, the first tick is on the first edge after the EN-setting edge.
- `irq_o` is a combinational AND of two register bits, so it is glitch-free and rises in the cycle after the underflow edge.
- Collision rules:
  - COUNT write in the same cycle as a tick: the written value wins and the tick is dropped for COUNT; the prescaler still wraps.
  - STATUS W1C in the same cycle as an underflow: the set wins and IF stays 1.
  - CTRL write in the same cycle as a one-shot underflow: the CTRL write value wins for EN.
  - PSC write while running: takes effect immediately in the compare. If `pcnt` > new PSC, `pcnt` keeps counting, wraps at 0xFFFF, then matches.
- Reset asserted mid-count returns everything to the reset values asynchronously; there is no partial state.

## Test plan
- Reset: assert `hreset_n` mid-run. Expect all addresses to read 0x0, and `irq_o` = 0, `tout_o` = 0 immediately.
- Continuous count:
  - Stimulus: write LOAD = 3, COUNT = 3, PSC = 0, then CTRL = 0x5 at edge E0.
  - Expect COUNT reads 2, 1, 0 after E1–E3.
  - At E4: IF = 1, `irq_o` = 1, COUNT = 3.
  - Underflow repeats every 4 cycles; writing STATUS = 1 drops `irq_o` the next cycle until the next underflow.
- Prescaler: PSC = 9, LOAD = COUNT = 100, EN = 1. Expect COUNT to decrement exactly once per 10 cycles, and 99 after 10 cycles.
- One-shot: LOAD = 5, COUNT = 2, PSC = 0, CTRL = 0x3. Expect IF = 1 after 3 ticks, CTRL reads 0x2, and COUNT stays 0 for 20 more cycles.
- Collisions:
  - STATUS W1C on the underflow edge: IF remains 1.
  - COUNT = 0x50 written on a tick edge: reads 0x50, not a decrement.
- Output and decode:
  - TOUT_EN = 1, PSC = 1, LOAD = 2: `tout_o` has a period of 12 cycles, toggling every 6.
  - A read of 0x18 returns 0.
  - A write to 0x18 changes no register.

Source files
------------

// File: rtl/apb_timer.sv
// apb_timer: zero-wait-state APB timer with a 16-bit prescaler, 32-bit auto-reload down-counter,
// one-shot mode, sticky underflow flag with maskable level IRQ, and a registered toggle output.
module apb_timer (
    input  logic        hclk,
    input  logic        hreset_n,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        irq_o,
    output logic        tout_o
);
    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_PSC    = 3'd1;
    localparam logic [2:0] A_LOAD   = 3'd2;
    localparam logic [2:0] A_COUNT  = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic        r_en;
    logic        r_oneshot;
    logic        r_irq_en;
    logic        r_tout_en;
    logic        r_if;
    logic        r_tout;
    logic [15:0] r_psc;
    logic [15:0] r_pcnt;
    logic [31:0] r_load;
    logic [31:0] r_count;

    logic        w_wr;
    logic [2:0]  w_addr;
    logic        w_tick;
    logic        w_unf;
    logic        w_unused;

    assign w_wr     = psel_i & penable_i & pwrite_i;
    assign w_addr   = paddr_i[4:2];
    assign w_tick   = r_en & (r_pcnt == r_psc);
    assign w_unf    = w_tick & (r_count == 32'd0);
    assign w_unused = ^{paddr_i[31:5], paddr_i[1:0]};

    // pcnt sits at 0 whenever EN is low, so the EN-setting write always starts a fresh prescale.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_pcnt <= 16'd0;
        end else if (!r_en || w_tick) begin
            r_pcnt <= 16'd0;
        end else begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_en      <= 1'b0;
            r_oneshot <= 1'b0;
            r_irq_en  <= 1'b0;
            r_tout_en <= 1'b0;
            r_if      <= 1'b0;
            r_tout    <= 1'b0;
            r_psc     <= 16'd0;
            r_load    <= 32'd0;
            r_count   <= 32'd0;
        end else begin
            // Underflow set has priority over a same-cycle W1C.
            if (w_unf) begin
                r_if <= 1'b1;
                if (r_tout_en) begin
                    r_tout <= ~r_tout;
                end
            end else if (w_wr && (w_addr == A_STATUS) && pwdata_i[0]) begin
                r_if <= 1'b0;
            end

            if (w_wr && (w_addr == A_CTRL)) begin
                r_en      <= pwdata_i[0];
                r_oneshot <= pwdata_i[1];
                r_irq_en  <= pwdata_i[2];
                r_tout_en <= pwdata_i[3];
            end else if (w_unf && r_oneshot) begin
                r_en <= 1'b0;
            end

            if (w_wr && (w_addr == A_PSC)) begin
                r_psc <= pwdata_i[15:0];
            end

            if (w_wr && (w_addr == A_LOAD)) begin
                r_load <= pwdata_i;
            end

            // A direct COUNT write swallows a coincident tick.
            if (w_wr && (w_addr == A_COUNT)) begin
                r_count <= pwdata_i;
            end else if (w_tick) begin
                if (r_count != 32'd0) begin
                    r_count <= r_count - 32'd1;
                end else if (!r_oneshot) begin
                    r_count <= r_load;
                end
            end
        end
    end

    always_comb begin
        prdata_o = 32'd0;
        if (psel_i && !pwrite_i) begin
            case (w_addr)
                A_CTRL:   prdata_o = {28'd0, r_tout_en, r_irq_en, r_oneshot, r_en};
                A_PSC:    prdata_o = {16'd0, r_psc};
                A_LOAD:   prdata_o = r_load;
                A_COUNT:  prdata_o = r_count;
                A_STATUS: prdata_o = {31'd0, r_if};
                default:  prdata_o = 32'd0;
            endcase
        end
    end

    assign irq_o  = r_if & r_irq_en;
    assign tout_o = r_tout;

endmodule

// File: tb/tb_apb_timer.sv
// Directed and randomized bench for apb_timer; a rule-level model tracks every clock edge.
module tb_apb_timer;
    logic        hclk;
    logic        hreset_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        irq;
    logic        tout;

    int errors;
    int checks;

    // reference model state
    logic        m_en, m_os, m_ie, m_te, m_if, m_tout;
    logic [15:0] m_psc;
    int unsigned m_pcnt;
    logic [31:0] m_load, m_count;

    apb_timer dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata),
        .irq_o     (irq),
        .tout_o    (tout)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic model_reset();
        m_en = 0; m_os = 0; m_ie = 0; m_te = 0; m_if = 0; m_tout = 0;
        m_psc = 0; m_pcnt = 0; m_load = 0; m_count = 0;
    endtask

    task automatic model_step(input logic s, input logic e, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
        logic wr_stb, tick, unf, was_en;
        wr_stb = s & e & w;
        was_en = m_en;
        tick   = m_en && (m_pcnt == int'(m_psc));
        unf    = tick && (m_count == 0);
        if (!was_en || tick) m_pcnt = 0;
        else m_pcnt = (m_pcnt + 1) % 65536;
        if (tick) begin
            if (m_count != 0) m_count = m_count - 1;
            else begin
                m_if = 1;
                if (m_te) m_tout = ~m_tout;
                if (m_os) m_en = 0;
                else m_count = m_load;
            end
        end
        if (wr_stb) begin
            case (a[4:2])
                3'd0: begin m_en = d[0]; m_os = d[1]; m_ie = d[2]; m_te = d[3]; end
                3'd1: m_psc = d[15:0];
                3'd2: m_load = d;
                3'd3: m_count = d;
                3'd4: if (d[0] && !unf) m_if = 0;
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a[4:2])
            3'd0: return {28'd0, m_te, m_ie, m_os, m_en};
            3'd1: return {16'd0, m_psc};
            3'd2: return m_load;
            3'd3: return m_count;
            3'd4: return {31'd0, m_if};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic e, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
        @(posedge hclk);
        model_step(s, e, w, a, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, 1'b1, a, d);
        cyc(1'b1, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        #1;
        check(tag, prdata, exp);
        psel = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        hreset_n = 1'b0;
        model_reset();
        #22 hreset_n = 1'b1;
        @(posedge hclk); #1;

        // reset state
        for (int i = 0; i < 8; i++) rd(32'(i * 4), 32'd0, "reset_read");
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_tout", {31'd0, tout}, 32'd0);

        // continuous mode, PSC=0, LOAD=3
        wr(32'h08, 32'd3); wr(32'h0C, 32'd3); wr(32'h04, 32'd0); wr(32'h00, 32'h5);
        rd(32'h0C, 32'd3, "cont_e0");
        idle(1); rd(32'h0C, 32'd2, "cont_e1");
        idle(1); rd(32'h0C, 32'd1, "cont_e2");
        idle(1); rd(32'h0C, 32'd0, "cont_e3");
        check("cont_irq_e3", {31'd0, irq}, 32'd0);
        idle(1); rd(32'h10, 32'd1, "cont_if_e4");
        check("cont_irq_e4", {31'd0, irq}, 32'd1);
        rd(32'h0C, 32'd3, "cont_reload_e4");
        wr(32'h10, 32'd1);
        check("w1c_irq_drop", {31'd0, irq}, 32'd0);
        rd(32'h0C, 32'd1, "cont_e6");
        idle(2);
        check("cont_irq_e8", {31'd0, irq}, 32'd1);
        rd(32'h0C, 32'd3, "cont_reload_e8");
        idle(2);
        wr(32'h10, 32'd1);
        rd(32'h10, 32'd1, "w1c_collide_if");
        rd(32'h0C, 32'd3, "w1c_collide_cnt");
        wr(32'h0C, 32'h50);
        rd(32'h0C, 32'h50, "cnt_write_tick");
        idle(1); rd(32'h0C, 32'h4F, "cnt_after_write");
        wr(32'h00, 32'd0);
        rd(32'h0C, 32'h4D, "disable_cnt");
        idle(5); rd(32'h0C, 32'h4D, "freeze_cnt");

        // prescaler PSC=9
        wr(32'h04, 32'd9); wr(32'h08, 32'd100); wr(32'h0C, 32'd100); wr(32'h00, 32'h1);
        idle(9);  rd(32'h0C, 32'd100, "psc_9cyc");
        idle(1);  rd(32'h0C, 32'd99, "psc_10cyc");
        idle(9);  rd(32'h0C, 32'd99, "psc_19cyc");
        idle(1);  rd(32'h0C, 32'd98, "psc_20cyc");
        wr(32'h00, 32'd0);

        // one-shot
        wr(32'h10, 32'd1); wr(32'h08, 32'd5); wr(32'h0C, 32'd2); wr(32'h04, 32'd0);
        wr(32'h00, 32'h3);
        idle(2); rd(32'h10, 32'd0, "os_if_before");
        idle(1); rd(32'h10, 32'd1, "os_if");
        rd(32'h00, 32'h2, "os_ctrl");
        rd(32'h0C, 32'd0, "os_cnt");
        idle(20); rd(32'h0C, 32'd0, "os_cnt_hold");

        // toggle output, PSC=1, LOAD=2 -> toggle every 6 cycles
        wr(32'h10, 32'd1); wr(32'h04, 32'd1); wr(32'h08, 32'd2); wr(32'h0C, 32'd2);
        wr(32'h00, 32'h9);
        idle(5); check("tout_c5",  {31'd0, tout}, 32'd0);
        idle(1); check("tout_c6",  {31'd0, tout}, 32'd1);
        idle(5); check("tout_c11", {31'd0, tout}, 32'd1);
        idle(1); check("tout_c12", {31'd0, tout}, 32'd0);
        idle(5); check("tout_c17", {31'd0, tout}, 32'd0);
        idle(1); check("tout_c18", {31'd0, tout}, 32'd1);

        // unmapped decode
        rd(32'h18, 32'd0, "rd_0x18");
        wr(32'h18, 32'hFFFF_FFFF);
        rd(32'h00, 32'h9, "wr18_ctrl");
        rd(32'h04, 32'h1, "wr18_psc");
        rd(32'h08, 32'h2, "wr18_load");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            logic [2:0]  ra;
            logic [31:0] a;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            ra = 3'($urandom_range(0, 7));
            a  = {27'd0, ra, 2'($urandom_range(0, 3))};
            if (op <= 3) begin
                idle($urandom_range(1, 6));
            end else if (op <= 6) begin
                case (ra)
                    3'd1:        d = $urandom_range(0, 3);
                    3'd2, 3'd3:  d = $urandom_range(0, 9);
                    3'd0:        d = $urandom_range(0, 15) | (($urandom_range(0, 1) == 1) ? 32'hF0 : 32'h0);
                    default:     d = $urandom;
                endcase
                wr(a, d);
            end else begin
                rd(a, model_read(a), "rand_read");
            end
            check("rand_irq",  {31'd0, irq},  {31'd0, m_if & m_ie});
            check("rand_tout", {31'd0, tout}, {31'd0, m_tout});
        end

        // asynchronous reset mid-run
        wr(32'h10, 32'd1); wr(32'h08, 32'd0); wr(32'h0C, 32'd0); wr(32'h04, 32'd0);
        wr(32'h00, 32'hD);
        idle(3);
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        check("pre_reset_tout", {31'd0, tout}, {31'd0, m_tout});
        #2 hreset_n = 1'b0;
        #1;
        model_reset();
        check("arst_irq", {31'd0, irq}, 32'd0);
        check("arst_tout", {31'd0, tout}, 32'd0);
        for (int i = 0; i < 8; i++) rd(32'(i * 4), 32'd0, "arst_read");
        @(negedge hclk);
        hreset_n = 1'b1;
        @(posedge hclk); #1;
        idle(3);
        rd(32'h0C, 32'd0, "post_reset_cnt");
        check("post_reset_tout", {31'd0, tout}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
